// File: rtl/upsp_ctrl_pkg.sv
// Shared types and geometry helpers for the up-sampling frame controller.
package upsp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } upsp_ctrl_state_e;

  // Source beats per frame.
  function automatic int in_beats(input int src_w, input int src_h);
    return src_w * src_h;
  endfunction

  // Output beats per frame: every source pixel becomes scale x scale pixels.
  function automatic int out_beats(input int src_w, input int src_h, input int scale);
    return src_w * src_h * scale * scale;
  endfunction

  // Bits needed to hold 0..max_val inclusive (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/upsp_frame_ctrl_if.sv
// Read/write beat handshakes between the access controller, this block and the core.
interface upsp_frame_ctrl_if #(
  parameter int RD_W = 24,
  parameter int WR_W = 24
);
  logic            ac_upsp_rvalid;
  logic            upsp_ac_rready;
  logic [RD_W-1:0] ac_upsp_rdata;
  logic            core_rvalid;
  logic            core_rready;
  logic [RD_W-1:0] core_rdata;
  logic            core_sof;
  logic            core_eol;
  logic            core_wvalid;
  logic            core_wready;
  logic [WR_W-1:0] core_wdata;
  logic            upsp_ac_wvalid;
  logic            ac_upsp_wready;
  logic [WR_W-1:0] upsp_ac_wdata;

  // Environment side: access controller and core.
  modport master (
    output ac_upsp_rvalid, ac_upsp_rdata, core_rready,
    output core_wvalid, core_wdata, ac_upsp_wready,
    input  upsp_ac_rready, core_rvalid, core_rdata, core_sof, core_eol,
    input  core_wready, upsp_ac_wvalid, upsp_ac_wdata
  );

  // Frame controller side.
  modport slave (
    input  ac_upsp_rvalid, ac_upsp_rdata, core_rready,
    input  core_wvalid, core_wdata, ac_upsp_wready,
    output upsp_ac_rready, core_rvalid, core_rdata, core_sof, core_eol,
    output core_wready, upsp_ac_wvalid, upsp_ac_wdata
  );
endinterface

// File: rtl/upsp_ctrl_pos_cnt.sv
// Column/row position of the next source pixel; column wraps and bumps the row.
module upsp_ctrl_pos_cnt
  import upsp_ctrl_pkg::*;
#(
  parameter int COLS = 960,
  parameter int ROWS = 540,
  localparam int COL_W = cnt_w(COLS - 1),
  localparam int ROW_W = cnt_w(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row
);

  // Clear has priority; each increment advances one pixel in raster order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (col == COL_W'(COLS - 1)) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/upsp_frame_ctrl.sv
// Frame controller: gates AC<->core beats by frame state, counts beats, flags completion.
module upsp_frame_ctrl
  import upsp_ctrl_pkg::*;
#(
  parameter int CRF_DATA_WIDTH     = 32,
  parameter int UPSP_RDDATA_WIDTH  = 24,
  parameter int UPSP_WRTDATA_WIDTH = 24,
  parameter int SRC_W              = 960,
  parameter int SRC_H              = 540,
  parameter int SCALE              = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CRF_DATA_WIDTH-1:0] UPSTR,
  output logic [CRF_DATA_WIDTH-1:0] UPENDR,
  upsp_frame_ctrl_if.slave          bus
);

  localparam int IN_BEATS  = in_beats(SRC_W, SRC_H);
  localparam int OUT_BEATS = out_beats(SRC_W, SRC_H, SCALE);
  localparam int RD_CNT_W  = cnt_w(IN_BEATS);
  localparam int WR_CNT_W  = cnt_w(OUT_BEATS);
  localparam int COL_W     = cnt_w(SRC_W - 1);
  localparam int ROW_W     = cnt_w(SRC_H);

  upsp_ctrl_state_e      state;
  logic                  upstr_q;
  logic [RD_CNT_W-1:0]   rd_cnt;
  logic [WR_CNT_W-1:0]   wr_cnt;
  logic                  done_q;
  logic                  busy_q;
  logic [COL_W-1:0]      in_col;
  logic [ROW_W-1:0]      in_row;

  logic run_st;
  logic drain_st;
  logic start;
  logic frame_clr;
  logic wr_open;
  logic rd_hs;
  logic wr_hs;
  logic rd_last;
  logic wr_fin;
  logic unused_upstr_hi;

  assign unused_upstr_hi = ^UPSTR[CRF_DATA_WIDTH-1:1];

  assign run_st    = (state == ST_RUN);
  assign drain_st  = (state == ST_DRAIN);
  assign start     = UPSTR[0] & ~upstr_q;
  assign frame_clr = start & ((state == ST_IDLE) | (state == ST_DONE));
  assign wr_open   = (run_st | drain_st) & (wr_cnt < WR_CNT_W'(OUT_BEATS));
  assign rd_hs     = bus.ac_upsp_rvalid & bus.core_rready & run_st;
  assign wr_hs     = bus.core_wvalid & bus.ac_upsp_wready & wr_open;
  assign rd_last   = rd_hs & (rd_cnt == RD_CNT_W'(IN_BEATS - 1));
  // Writes are complete if already at the target or the final beat lands now.
  assign wr_fin    = (wr_cnt == WR_CNT_W'(OUT_BEATS)) |
                     (wr_hs & (wr_cnt == WR_CNT_W'(OUT_BEATS - 1)));

  // Start-request history for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) upstr_q <= 1'b0;
    else     upstr_q <= UPSTR[0];
  end

  // Frame FSM with beat counters and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      rd_cnt <= '0;
      wr_cnt <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state  <= ST_RUN;
            rd_cnt <= '0;
            wr_cnt <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (rd_hs) rd_cnt <= rd_cnt + RD_CNT_W'(1);
          if (wr_hs) wr_cnt <= wr_cnt + WR_CNT_W'(1);
          if (rd_last) begin
            if (wr_fin) begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (wr_hs) wr_cnt <= wr_cnt + WR_CNT_W'(1);
          if (wr_fin) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  upsp_ctrl_pos_cnt #(
    .COLS (SRC_W),
    .ROWS (SRC_H)
  ) u_pos (
    .clk (clk),
    .rst (rst),
    .clr (frame_clr),
    .inc (rd_hs),
    .col (in_col),
    .row (in_row)
  );

  assign bus.core_rvalid    = bus.ac_upsp_rvalid & run_st;
  assign bus.upsp_ac_rready = bus.core_rready & run_st;
  assign bus.core_rdata     = UPSP_RDDATA_WIDTH'(bus.ac_upsp_rdata);
  assign bus.core_sof       = (in_col == '0) & (in_row == '0);
  assign bus.core_eol       = (in_col == COL_W'(SRC_W - 1));

  assign bus.upsp_ac_wvalid = bus.core_wvalid & wr_open;
  assign bus.core_wready    = bus.ac_upsp_wready & wr_open;
  assign bus.upsp_ac_wdata  = UPSP_WRTDATA_WIDTH'(bus.core_wdata);

  assign UPENDR = CRF_DATA_WIDTH'({busy_q, done_q});

endmodule

// File: doc/upsp_frame_ctrl.md
# upsp_frame_ctrl

Frame-level controller placed between the AXI access controller (AC) and the up-sampling core. Launches a frame when software sets the CRF start register UPSTR. Passes read beats from AC to the core and write beats from the core to AC only while a frame is active, and counts input/output beats against the frame geometry. Adds start-of-frame and end-of-line sideband for the core, and reports completion through the end register UPENDR.

## Interface
- CRF_DATA_WIDTH, 32, config register width
- UPSP_RDDATA_WIDTH, 24, input pixel width
- UPSP_WRTDATA_WIDTH, 24, output pixel width
- SRC_W, 960, source pixels per line
- SRC_H, 540, source lines per frame
- SCALE, 4, up-sampling factor per axis
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- UPSTR  in  CRF_DATA_WIDTH  bit0 = start request; other bits ignored
- UPENDR  out  CRF_DATA_WIDTH  bit0 = frame done (sticky); bit1 = busy; others 0
- ac_upsp_rvalid  in  1  AC read beat valid
- upsp_ac_rready  out  1  ready toward AC
- ac_upsp_rdata  in  UPSP_RDDATA_WIDTH  source pixel
- core_rvalid  out  1  pixel valid to core
- core_rready  in  1  core accepts pixel
- core_rdata  out  UPSP_RDDATA_WIDTH  = ac_upsp_rdata
- core_sof  out  1  current core_rdata is pixel (0,0)
- core_eol  out  1  current core_rdata is last pixel of a line
- core_wvalid  in  1  core output valid
- core_wready  out  1  ready to core
- core_wdata  in  UPSP_WRTDATA_WIDTH  output pixel
- upsp_ac_wvalid  out  1  write beat valid to AC
- ac_upsp_wready  in  1  AC accepts write beat
- upsp_ac_wdata  out  UPSP_WRTDATA_WIDTH  = core_wdata

## Operation
- Beat counts: IN_BEATS = SRC_W*SRC_H; OUT_BEATS = IN_BEATS*SCALE*SCALE.
- Counter widths: rd_cnt is $clog2(IN_BEATS+1) bits; wr_cnt is $clog2(OUT_BEATS+1) bits. Unsigned; counters never wrap.
- Start pulse: start = UPSTR[0] & ~upstr_q, where upstr_q is UPSTR[0] registered.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE, start=1 -> RUN. Clear rd_cnt, wr_cnt, in_col, in_row; clear done.
  - RUN, last read accepted (rd_cnt reaches IN_BEATS): -> DRAIN. If wr_cnt also reaches OUT_BEATS in the same cycle -> DONE.
  - DRAIN, last write accepted (wr_cnt reaches OUT_BEATS): -> DONE.
  - A start pulse in RUN or DRAIN is ignored.
- Read channel: open in RUN only.
  - core_rvalid = ac_upsp_rvalid & RUN.
  - upsp_ac_rready = core_rready & RUN.
- Write channel: open in RUN or DRAIN while wr_cnt < OUT_BEATS.
  - upsp_ac_wvalid = core_wvalid & open.
  - core_wready = ac_upsp_wready & open.
- Read position: in_col wraps at SRC_W-1 to 0 and increments in_row on each accepted read beat.
  - core_sof = (in_col==0 & in_row==0).
  - core_eol = (in_col==SRC_W-1).
  - Both are decoded from registers and are valid whenever core_rvalid=1.
- UPENDR[0] = 1 in DONE; UPENDR[1] = 1 in RUN or DRAIN.
- Reset mid-frame: all state is discarded immediately and the block returns to IDLE. No beats pass until the next start pulse.

## Timing
- Reset values: state IDLE; counters 0; upstr_q 0; UPENDR 0. All handshake outputs are 0, because they are gated by state.
- Start: UPSTR[0] rises in cycle t -> state is RUN in t+1 -> upsp_ac_rready can be 1 in t+1.
- Data path: zero latency, purely combinational, no buffering.
- Valid outputs never depend on the opposite ready.
- State exit: accepting the last read in cycle t makes state DRAIN in t+1 and upsp_ac_rready 0 in t+1. Same rule for the last write and DONE.
- Done: UPENDR[0] is 1 in the cycle after the last write handshake. It stays 1 until the next start pulse or reset.

## Structure
- upsp_ctrl_pkg holds:
  - state enum upsp_ctrl_state_e;
  - functions for IN_BEATS and OUT_BEATS and their counter widths.
- Sub-module upsp_ctrl_pos_cnt: col/row position counter with wrap, clear and increment inputs. It is used for in_col/in_row.

## Test plan
- Params SRC_W=4, SRC_H=2, SCALE=2 (8 in, 32 out). Pulse UPSTR[0], stream 8 reads and 32 writes with ready/valid always 1 -> state goes DRAIN then DONE; UPENDR=0x1 exactly one cycle after beat 32.
- Reads before start: ac_upsp_rvalid=1 while IDLE -> upsp_ac_rready=0 and core_rvalid=0; no counter change.
- Random backpressure on core_rready and ac_upsp_wready -> exactly 8 read and 32 write handshakes; sof on beat 0; eol on beats 3 and 7.
- Extra core_wvalid after beat 32 -> core_wready=0; upsp_ac_wvalid=0.
- Second start pulse during RUN -> ignored. Start pulse in DONE -> UPENDR reads 0x2 next cycle and the counters restart from 0.
- Assert rst after 5 reads -> state IDLE and UPENDR=0 immediately; a new start then processes a full 8/32 frame.
